// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the serial arithmetic blocks: default operand width
// and the subtractor FSM state encoding.
package serial_subtractor_pkg;

    // Default operand width, shared with the adder blocks.
    localparam int unsigned DEFAULT_WIDTH = 3;

    // Two-state sequencer: waiting for a request, or resolving bits.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell, the counterpart of full_adder.
// Ports:
//   a    - minuend bit
//   b    - subtrahend bit
//   bin  - borrow in
//   d    - difference bit  (a - b - bin)
//   bout - borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = first_bin - second_bin (mod 2^WIDTH),
// one bit per clock through a single full_subtractor cell, LSB first.
// Ports:
//   clock      - system clock, rising edge
//   reset_n    - asynchronous active-low reset
//   start      - request pulse, sampled only while idle
//   first_bin  - minuend, captured on an accepted start
//   second_bin - subtrahend, captured on an accepted start
//   busy       - high while a subtraction is in progress
//   done       - one-cycle pulse when D/bout are newly updated
//   D          - difference, held until the next completion
//   bout       - final borrow (first_bin < second_bin), held with D
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] first_bin,
    input  logic [WIDTH-1:0] second_bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             bout
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] res;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             cell_d;
    logic             cell_bo;
    logic             load_c;
    logic             step_c;
    logic             last_c;

    // Shared arithmetic cell, time-multiplexed across all bit positions.
    full_subtractor u_cell (
        .a    (shift_a[0]),
        .b    (shift_b[0]),
        .bin  (borrow),
        .d    (cell_d),
        .bout (cell_bo)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(WIDTH - 1)) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath control strobes.
    always_comb begin
        load_c = 1'b0;
        step_c = 1'b0;
        last_c = 1'b0;
        case (state)
            ST_IDLE: load_c = start;
            ST_RUN: begin
                step_c = 1'b1;
                last_c = (cnt == CNT_W'(WIDTH - 1));
            end
            default: ;
        endcase
    end

    // Operand/result shifters, borrow, counter and registered outputs.
    // D and bout only change on the final bit so no partial result leaks out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shift_a <= '0;
            shift_b <= '0;
            res     <= '0;
            borrow  <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            D       <= '0;
            bout    <= 1'b0;
        end else begin
            done <= last_c;
            if (load_c) begin
                shift_a <= first_bin;
                shift_b <= second_bin;
                res     <= '0;
                borrow  <= 1'b0;
                cnt     <= '0;
                busy    <= 1'b1;
            end else if (step_c) begin
                shift_a <= {1'b0, shift_a[WIDTH-1:1]};
                shift_b <= {1'b0, shift_b[WIDTH-1:1]};
                res     <= {cell_d, res[WIDTH-1:1]};
                borrow  <= cell_bo;
                if (last_c) begin
                    D    <= {cell_d, res[WIDTH-1:1]};
                    bout <= cell_bo;
                    busy <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
